pipeline_reg: RTL

PIPELINE_REG -- requirements
Module: pipeline_reg

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/pipe_data_reg.sv | 22 ++
 rtl/pipeline_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the two-entry skid pipeline register.
package pipeline_pkg;

  // Number of entries held: EMPTY=0, ONE=1, FULL=2 (3 is never used).
  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Entry count for a given state; the unused encoding maps to zero.
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// N-bit data register with load enable and asynchronous reset to RESET_VAL.
module pipe_data_reg #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] data_d,
  output logic [N-1:0] data_q
);

  // Capture data_d only when load is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (load) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipeline_reg.sv
// Two-entry valid/ready pipeline register with a skid slot, so in_ready
// depends only on registered state while still sustaining one transfer
// per cycle.
module pipeline_reg
  import pipeline_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  pipe_state_e  state_q;
  pipe_state_e  state_d;
  logic         acc;
  logic         fire;
  logic         main_load;
  logic         skid_load;
  logic [N-1:0] main_d;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;

  // Handshake outputs decoded purely from the registered state.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q == ONE) || (state_q == FULL);
    occupancy = occ_of(state_q);
    out_data  = main_q;
    acc       = in_valid & in_ready;
    fire      = out_valid & out_ready;
  end

  // Next state and register load selects; flush squashes everything.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            state_d   = ONE;
            main_d    = skid_q;
            main_load = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(.N(N), .RESET_VAL(RESET_VAL)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .data_d (main_d),
    .data_q (main_q)
  );

  pipe_data_reg #(.N(N), .RESET_VAL(RESET_VAL)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .data_d (in_data),
    .data_q (skid_q)
  );

endmodule
